// File: rtl/piso_serial_transmitter.sv
// -----------------------------------------------------------------------------
// piso_serial_transmitter
// Parallel-in, serial-out transmitter feeding a shift-register receiver.
// A WIDTH-bit word is accepted through a valid/ready handshake while idle and
// then presented one bit per cycle on serial_out, each bit qualified by
// shift_strobe. A one-cycle frame_done pulse follows the last bit.
//
// Ports
//   clockpulse    in   1      rising-edge clock
//   clear         in   1      asynchronous active-low reset
//   data_in       in   WIDTH  parallel word, sampled on accept
//   data_valid    in   1      source offers data_in
//   data_ready    out  1      high in IDLE (accept possible)
//   hold          in   1      pause transmission (only meaningful in SHIFT)
//   serial_out    out  1      registered serial bit stream
//   shift_strobe  out  1      registered; high when serial_out carries a bit
//   busy          out  1      high in SHIFT and DONE
//   frame_done    out  1      registered one-cycle pulse after the last bit
//
// serial_out, shift_strobe and frame_done come straight from flops, so hold
// acts through a register: hold seen high on a clock edge during SHIFT
// keeps the following cycle unstrobed, with serial_out frozen on the last
// bit that was presented.
// -----------------------------------------------------------------------------
module piso_serial_transmitter #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             hold,
  output logic             serial_out,
  output logic             shift_strobe,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             so_r, so_s;
  logic             strobe_r, strobe_s;
  logic             done_r, done_s;

  // Bit at the transmit end of the register.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the register one place toward the transmit end.
  function automatic logic [WIDTH-1:0] shift_to_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_s  = state_r;
    sreg_s   = sreg_r;
    cnt_s    = cnt_r;
    so_s     = so_r;
    strobe_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (data_valid) begin
          state_s  = ST_SHIFT;
          sreg_s   = data_in;
          cnt_s    = {CNT_W{1'b0}};
          so_s     = head_bit(data_in);
          strobe_s = 1'b1;
        end else begin
          so_s = IDLE_LEVEL;
        end
      end
      ST_SHIFT: begin
        if (strobe_r) begin
          // The bit shown this cycle is consumed by the receiver at this edge.
          if (cnt_r == LAST_CNT) begin
            state_s = ST_DONE;
            so_s    = IDLE_LEVEL;
            done_s  = 1'b1;
          end else begin
            sreg_s = shift_to_head(sreg_r);
            cnt_s  = cnt_r + CNT_W'(1);
            if (hold) begin
              so_s = so_r;
            end else begin
              so_s     = head_bit(shift_to_head(sreg_r));
              strobe_s = 1'b1;
            end
          end
        end else begin
          // Paused: the register already holds the next bit at its head.
          if (hold) begin
            so_s = so_r;
          end else begin
            so_s     = head_bit(sreg_r);
            strobe_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        so_s    = IDLE_LEVEL;
      end
      default: begin
        state_s = ST_IDLE;
        sreg_s  = {WIDTH{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        so_s    = IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      state_r  <= ST_IDLE;
      sreg_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      so_r     <= IDLE_LEVEL;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sreg_r   <= sreg_s;
      cnt_r    <= cnt_s;
      so_r     <= so_s;
      strobe_r <= strobe_s;
      done_r   <= done_s;
    end
  end

  assign data_ready   = (state_r == ST_IDLE);
  assign busy         = (state_r != ST_IDLE);
  assign serial_out   = so_r;
  assign shift_strobe = strobe_r;
  assign frame_done   = done_r;

endmodule

// File: tb/tb_piso_serial_transmitter.sv
// -----------------------------------------------------------------------------
// tb_piso_serial_transmitter
// Three transmitters: A (WIDTH=4, MSB first), B (WIDTH=4, LSB first) and
// C (WIDTH=8, MSB first). Expected bits are queued at each accept and popped
// whenever a strobe is seen; a receiver model rebuilds each word.
// -----------------------------------------------------------------------------
module tb_piso_serial_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;

  logic [3:0] a_data;  logic a_valid, a_ready, a_hold, a_serial, a_strobe, a_busy, a_done;
  logic [3:0] b_data;  logic b_valid, b_ready, b_hold, b_serial, b_strobe, b_busy, b_done;
  logic [7:0] c_data;  logic c_valid, c_ready, c_hold, c_serial, c_strobe, c_busy, c_done;

  piso_serial_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clockpulse(clk), .clear(clear), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .hold(a_hold), .serial_out(a_serial),
    .shift_strobe(a_strobe), .busy(a_busy), .frame_done(a_done));

  piso_serial_transmitter #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clockpulse(clk), .clear(clear), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .hold(b_hold), .serial_out(b_serial),
    .shift_strobe(b_strobe), .busy(b_busy), .frame_done(b_done));

  piso_serial_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (
    .clockpulse(clk), .clear(clear), .data_in(c_data), .data_valid(c_valid),
    .data_ready(c_ready), .hold(c_hold), .serial_out(c_serial),
    .shift_strobe(c_strobe), .busy(c_busy), .frame_done(c_done));

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit qa[$];
  bit qb[$];
  bit qc[$];
  int a_strobes = 0, a_dones = 0;
  int b_strobes = 0, b_dones = 0;
  int c_strobes = 0, c_dones = 0;
  logic [3:0] a_rx = 4'd0;
  logic [3:0] b_rx = 4'd0;
  logic [7:0] c_rx = 8'd0;

  typedef struct {
    logic [3:0] data;
    int         hold_after;  // strobe number after which hold goes high (0: none)
    int         hold_len;    // edges hold stays high
    int         exp_len;     // cycles from accept edge to the frame_done cycle
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cycle++;

  // Scoreboard: pop and compare on every strobed cycle; rebuild received words.
  always @(negedge clk) begin
    if (a_strobe) begin
      a_strobes++;
      a_rx = {a_rx[2:0], a_serial};
      if (qa.size() == 0) check("a_unexpected_strobe", 32'd1, 32'd0);
      else check("a_bit", {31'd0, a_serial}, {31'd0, qa.pop_front()});
    end
    if (a_done) a_dones++;
    if (b_strobe) begin
      b_strobes++;
      b_rx = {b_serial, b_rx[3:1]};
      if (qb.size() == 0) check("b_unexpected_strobe", 32'd1, 32'd0);
      else check("b_bit", {31'd0, b_serial}, {31'd0, qb.pop_front()});
    end
    if (b_done) b_dones++;
    if (c_strobe) begin
      c_strobes++;
      c_rx = {c_rx[6:0], c_serial};
      if (qc.size() == 0) check("c_unexpected_strobe", 32'd1, 32'd0);
      else check("c_bit", {31'd0, c_serial}, {31'd0, qc.pop_front()});
    end
    if (c_done) c_dones++;
  end

  // Send one word through A, optionally pausing with hold, and check the frame.
  task automatic send_a(input logic [3:0] d, input int hold_after, input int hold_len,
                        input int exp_len, input string tag);
    int cyc;
    int seen;
    int done0;
    bit fin;
    nclk();
    done0 = a_dones;
    check({tag, "_ready"}, {31'd0, a_ready}, 32'd1);
    a_valid = 1'b1;
    a_data  = d;
    @(posedge clk);
    for (int i = 3; i >= 0; i--) qa.push_back(d[i]);
    #1;
    a_valid = 1'b0;
    a_data  = ~d;
    cyc  = 0;
    seen = 0;
    fin  = 1'b0;
    while (!fin && cyc < 40) begin
      nclk();
      cyc++;
      if (a_strobe) seen++;
      if (a_done) begin
        fin = 1'b1;
        check({tag, "_done_busy"}, {31'd0, a_busy}, 32'd1);
        check({tag, "_done_level"}, {31'd0, a_serial}, 32'd0);
        check({tag, "_done_strobe"}, {31'd0, a_strobe}, 32'd0);
      end else if (a_strobe && seen == hold_after && hold_len > 0) begin
        a_hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          nclk();
          cyc++;
          check({tag, "_hold_strobe"}, {31'd0, a_strobe}, 32'd0);
          check({tag, "_hold_level"}, {31'd0, a_serial}, {31'd0, d[4-hold_after]});
        end
        a_hold = 1'b0;
      end
    end
    check({tag, "_frame_len"}, cyc, exp_len);
    check({tag, "_rx_word"}, {28'd0, a_rx}, {28'd0, d});
    check({tag, "_done_count"}, a_dones - done0, 32'd1);
    check({tag, "_queue_empty"}, qa.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   d0, t1, t2, n;
    vecs[0] = '{4'b1011, 0, 0, 5};
    vecs[1] = '{4'b1011, 2, 3, 8};
    vecs[2] = '{4'b0110, 0, 0, 5};
    vecs[3] = '{4'b0000, 0, 0, 5};
    vecs[4] = '{4'b1111, 1, 2, 7};
    vecs[5] = '{4'b0101, 3, 1, 6};

    a_data = 4'd0; a_valid = 1'b0; a_hold = 1'b0;
    b_data = 4'd0; b_valid = 1'b0; b_hold = 1'b0;
    c_data = 8'd0; c_valid = 1'b0; c_hold = 1'b0;
    clear = 1'b1;
    #2 clear = 1'b0;
    #1;
    check("rst_ready",  {31'd0, a_ready},  32'd1);
    check("rst_serial", {31'd0, a_serial}, 32'd0);
    check("rst_strobe", {31'd0, a_strobe}, 32'd0);
    check("rst_busy",   {31'd0, a_busy},   32'd0);
    check("rst_done",   {31'd0, a_done},   32'd0);
    check("rst_ready_b", {31'd0, b_ready}, 32'd1);
    check("rst_ready_c", {31'd0, c_ready}, 32'd1);
    @(negedge clk);
    #1 clear = 1'b1;

    // Plain frame and a frame paused for three cycles after the second bit.
    for (int i = 0; i < 2; i++) send_a(vecs[i].data, vecs[i].hold_after, vecs[i].hold_len, vecs[i].exp_len, $sformatf("vec%0d", i));

    // Reset in the middle of a frame.
    nclk();
    a_valid = 1'b1;
    a_data  = 4'b1011;
    @(posedge clk);
    for (int i = 3; i >= 0; i--) qa.push_back(a_data[i]);
    #1 a_valid = 1'b0;
    nclk(); nclk(); nclk();
    check("midrst_3rd_strobe", {31'd0, a_strobe}, 32'd1);
    d0 = a_dones;
    clear = 1'b0;
    #1;
    check("midrst_serial", {31'd0, a_serial}, 32'd0);
    check("midrst_busy",   {31'd0, a_busy},   32'd0);
    check("midrst_ready",  {31'd0, a_ready},  32'd1);
    check("midrst_strobe", {31'd0, a_strobe}, 32'd0);
    qa.delete();
    nclk();
    clear = 1'b1;
    repeat (4) nclk();
    check("midrst_no_done", a_dones - d0, 32'd0);

    for (int i = 2; i < 6; i++) send_a(vecs[i].data, vecs[i].hold_after, vecs[i].hold_len, vecs[i].exp_len, $sformatf("vec%0d", i));

    // Back-to-back words with data_valid held high.
    nclk();
    a_valid = 1'b1;
    a_data  = 4'hA;
    @(posedge clk);
    for (int i = 3; i >= 0; i--) qa.push_back(a_data[i]);
    #1;
    t1 = cycle;
    a_data = 4'h5;
    n = 0;
    while (!a_ready && n < 20) begin
      nclk();
      n++;
    end
    @(posedge clk);
    for (int i = 3; i >= 0; i--) qa.push_back(a_data[i]);
    #1;
    t2 = cycle;
    a_valid = 1'b0;
    check("b2b_spacing", t2 - t1, 32'd6);
    check("b2b_first_word", {28'd0, a_rx}, 32'hA);
    n = 0;
    while (!a_done && n < 20) begin
      nclk();
      n++;
    end
    check("b2b_second_done", {31'd0, a_done}, 32'd1);
    check("b2b_second_word", {28'd0, a_rx}, 32'h5);
    check("b2b_queue_empty", qa.size(), 32'd0);

    // LSB-first frame with a stray data_valid mid-frame.
    nclk();
    b_valid = 1'b1;
    b_data  = 4'b1000;
    @(posedge clk);
    for (int i = 0; i < 4; i++) qb.push_back(b_data[i]);
    #1 b_valid = 1'b0;
    nclk(); nclk();
    b_valid = 1'b1;
    b_data  = 4'hF;
    check("lsb_busy_ready", {31'd0, b_ready}, 32'd0);
    nclk();
    b_valid = 1'b0;
    repeat (12) nclk();
    check("lsb_strobes", b_strobes, 32'd4);
    check("lsb_dones",   b_dones,   32'd1);
    check("lsb_rx_word", {28'd0, b_rx}, 32'h8);
    check("lsb_queue_empty", qb.size(), 32'd0);

    // Eight-bit frame.
    nclk();
    c_valid = 1'b1;
    c_data  = 8'hC3;
    @(posedge clk);
    for (int i = 7; i >= 0; i--) qc.push_back(c_data[i]);
    #1;
    c_valid = 1'b0;
    c_data  = 8'h00;
    n = 0;
    while (!c_done && n < 30) begin
      nclk();
      n++;
    end
    check("w8_frame_len", n, 32'd9);
    repeat (5) nclk();
    check("w8_strobes", c_strobes, 32'd8);
    check("w8_dones",   c_dones,   32'd1);
    check("w8_rx_word", {24'd0, c_rx}, 32'hC3);
    check("w8_queue_empty", qc.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
